// File: rtl/candy_mem_rd.sv
// ----------------------------------------------------------------------------
// candy_mem_rd
//
// Read side of the SRAM access path. The execute stage hands in tagged read
// requests. Each accepted request drives the SRAM read port in the same cycle.
// The request tag then follows the fixed SRAM read latency through a small
// shift register. When the data comes back it is captured, together with its
// tag, into a response FIFO. A valid/ready interface drains that FIFO.
//
// Flow control is credit based. The number of credits equals the FIFO depth.
// A request may only be accepted while a credit is free. Every read in
// flight or buffered therefore already owns a FIFO slot, so the FIFO cannot
// overflow.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             synchronous discard of every in-flight and buffered read
//   req_valid/ready   request handshake; req_addr, req_tag carry the request
//   sram_ren/raddr    SRAM read port, driven combinationally on accept
//   sram_rdata        SRAM read data, valid RD_LAT cycles after sram_ren
//   rsp_valid/ready   response handshake; rsp_data, rsp_tag are the FIFO head
//   busy              high while any credit is outstanding
// ----------------------------------------------------------------------------
module candy_mem_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 5,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX     = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [TAG_W-1:0]  fifo_tag  [DEPTH];

  logic [RD_LAT-1:0] pipe_valid;
  logic [TAG_W-1:0]  pipe_tag [RD_LAT];

  logic accept;
  logic pop;
  logic fifo_wr;
  logic fifo_nonempty;

  // Wrapping pointer increment. DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Request side. A free credit guarantees a FIFO slot for this read.
  assign req_ready  = !rst && !flush && (credits != '0);
  assign accept     = req_valid && req_ready;
  assign sram_ren   = accept;
  assign sram_raddr = accept ? req_addr : '0;

  // Response side. Outputs are zeroed whenever the head is not valid.
  // A pop is ignored during flush, because flush empties the FIFO anyway.
  assign fifo_nonempty = (fifo_count != '0);
  assign rsp_valid     = !rst && fifo_nonempty;
  assign rsp_data      = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_tag       = rsp_valid ? fifo_tag[rd_ptr]  : '0;
  assign pop           = rsp_valid && rsp_ready && !flush;

  // Returning data belongs to a live read only if its pipe bit survived.
  // During flush, the data of a read that was already issued is dropped here.
  assign fifo_wr = pipe_valid[RD_LAT-1] && !flush && !rst;

  assign busy = !rst && (credits != FULL_CREDITS);

  // Latency pipe: the tag and a valid bit advance one stage per cycle. The
  // last stage lines up with the cycle in which sram_rdata is valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Tags need no reset, because the valid bits qualify them.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // FIFO storage. Entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= sram_rdata;
      fifo_tag[wr_ptr]  <= pipe_tag[RD_LAT-1];
    end
  end

  // FIFO pointers and occupancy. A simultaneous write and pop moves both
  // pointers and leaves the count unchanged. This also holds at one entry,
  // because the new write lands in the slot after the head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit counter: an accept takes a credit and a pop returns one. A
  // returned credit shows up on req_ready in the following cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      credits <= FULL_CREDITS;
    end else begin
      case ({pop, accept})
        2'b10:   credits <= credits + CNT_W'(1);
        2'b01:   credits <= credits - CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_candy_mem_rd.sv
// ----------------------------------------------------------------------------
// tb_candy_mem_rd
//
// Directed cycle-by-cycle bench for candy_mem_rd (default parameters:
// RD_LAT=1, DEPTH=4).
//
// A behavioural SRAM returns a fixed data pattern derived from the address
// one cycle after sram_ren. Between reads it returns a poison word.
//
// Each cycle, inputs are driven 1ns after the rising edge. The outputs are
// compared 1ns later against hand-derived values.
// ----------------------------------------------------------------------------
module tb_candy_mem_rd;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int outstanding = 0;
  logic [ADDR_W-1:0] base = '0;

  candy_mem_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .RD_LAT(1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_tag(req_tag),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the SRAM as seen by the bench.
  function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
    sram_word = (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  // SRAM with a one-cycle read latency; it returns poison when not enabled.
  always @(posedge clk) begin
    sram_rdata <= sram_ren ? sram_word(sram_raddr) : 32'hBAADF00D;
  end

  // Reads accepted but not yet popped must never exceed the FIFO depth.
  always @(posedge clk) begin
    if (rst || flush) begin
      outstanding <= 0;
    end else begin
      outstanding <= outstanding + int'(req_valid && req_ready) - int'(rsp_valid && rsp_ready);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("no_overflow", 64'(outstanding > DEPTH), 64'd0);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check every output against the expectations,
  // then return just after the next rising edge.
  // The request address is base + tag. Expected response data follows from
  // the expected tag.
  task automatic applyStimulus(input bit rv, input logic [TAG_W-1:0] tg, input bit rr, input bit fl,
                               input bit e_rdy, input bit e_v, input logic [TAG_W-1:0] e_tag,
                               input bit e_busy);
    logic [ADDR_W-1:0] a;
    a         = base + ADDR_W'(tg);
    req_valid = rv;
    req_tag   = tg;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    #1;
    checkOutput("req_ready",  64'(req_ready),  64'(e_rdy));
    checkOutput("sram_ren",   64'(sram_ren),   64'(rv & e_rdy));
    checkOutput("sram_raddr", 64'(sram_raddr), (rv & e_rdy) ? 64'(a) : 64'd0);
    checkOutput("rsp_valid",  64'(rsp_valid),  64'(e_v));
    checkOutput("rsp_tag",    64'(rsp_tag),    e_v ? 64'(e_tag) : 64'd0);
    checkOutput("rsp_data",   64'(rsp_data),   e_v ? 64'(sram_word(base + ADDR_W'(e_tag))) : 64'd0);
    checkOutput("busy",       64'(busy),       64'(e_busy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_addr = 16'h0055;
    req_tag = 5'd9; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // While in reset, every output is at its reset value, even with a request offered.
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_sram_ren", 64'(sram_ren), 64'd0);
    checkOutput("rst_sram_raddr", 64'(sram_raddr), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // 1: single read, addr 0x0010 tag 3 -> DEADBEEF visible two cycles later
    $display("[TB] single request");
    base = 16'h000D;
    applyStimulus(1, 5'd3, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(0, 5'd0, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 1, 5'd3, 1);
    applyStimulus(0, 5'd0, 0, 0,  1, 0, 5'd0, 0);

    // 2: eight back-to-back reads with the consumer always ready
    $display("[TB] back-to-back");
    base = 16'h0000;
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(c < 8, 5'(c), 1, 0,  1, (c >= 2 && c <= 9), 5'(c - 2), (c >= 1 && c <= 9));
    end

    // 3: backpressure; four credits taken, then stalls until pops free them
    $display("[TB] backpressure");
    base = 16'h0020;
    applyStimulus(1, 5'd0, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(1, 5'd1, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(1, 5'd2, 0, 0,  1, 1, 5'd0, 1);
    applyStimulus(1, 5'd3, 0, 0,  1, 1, 5'd0, 1);
    applyStimulus(1, 5'd4, 0, 0,  0, 1, 5'd0, 1);
    applyStimulus(1, 5'd4, 0, 0,  0, 1, 5'd0, 1);
    applyStimulus(1, 5'd4, 1, 0,  0, 1, 5'd0, 1);
    applyStimulus(1, 5'd4, 1, 0,  1, 1, 5'd1, 1);
    applyStimulus(1, 5'd5, 1, 0,  1, 1, 5'd2, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 1, 5'd3, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 1, 5'd4, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 1, 5'd5, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 0, 5'd0, 0);

    // 4: pop of the single entry coincides with the write of the next one
    $display("[TB] pop and write at one entry");
    applyStimulus(1, 5'd10, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(1, 5'd11, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(1, 5'd12, 1, 0,  1, 1, 5'd10, 1);
    applyStimulus(0, 5'd0,  0, 0,  1, 1, 5'd11, 1);
    applyStimulus(0, 5'd0,  1, 0,  1, 1, 5'd11, 1);
    applyStimulus(0, 5'd0,  1, 0,  1, 1, 5'd12, 1);
    applyStimulus(0, 5'd0,  1, 0,  1, 0, 5'd0, 0);

    // 5: flush with two buffered and one read in the pipe
    $display("[TB] flush");
    applyStimulus(1, 5'd0, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(1, 5'd1, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(1, 5'd2, 0, 0,  1, 1, 5'd0, 1);
    applyStimulus(1, 5'd3, 1, 1,  0, 1, 5'd0, 1);
    applyStimulus(0, 5'd0, 1, 0,  1, 0, 5'd0, 0);
    applyStimulus(0, 5'd0, 1, 0,  1, 0, 5'd0, 0);

    // 6: reset with three reads outstanding, then normal operation again
    $display("[TB] mid-stream reset");
    applyStimulus(1, 5'd0, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(1, 5'd1, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(1, 5'd2, 0, 0,  1, 1, 5'd0, 1);
    rst = 1'b1;
    req_valid = 1'b1;
    #1;
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("midrst_sram_ren", 64'(sram_ren), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(1, 5'd9, 1, 0,  0, 0, 5'd0, 0);
    rst = 1'b0;
    applyStimulus(1, 5'd20, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(0, 5'd0,  0, 0,  1, 0, 5'd0, 1);
    applyStimulus(0, 5'd0,  1, 0,  1, 1, 5'd20, 1);
    // All four credits are available again after the reset.
    applyStimulus(1, 5'd21, 0, 0,  1, 0, 5'd0, 0);
    applyStimulus(1, 5'd22, 0, 0,  1, 0, 5'd0, 1);
    applyStimulus(1, 5'd23, 0, 0,  1, 1, 5'd21, 1);
    applyStimulus(1, 5'd24, 0, 0,  1, 1, 5'd21, 1);
    applyStimulus(1, 5'd25, 0, 0,  0, 1, 5'd21, 1);
    applyStimulus(0, 5'd0,  0, 1,  0, 1, 5'd21, 1);
    applyStimulus(0, 5'd0,  0, 0,  1, 0, 5'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
